// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//
// Parallel-to-serial stage feeding a 001 sequence detector. Words of WIDTH bits
// are accepted over a valid/ready handshake and shifted out MSB-first, one bit
// per clock. When no data bit is being sent, ser_out carries IDLE_BIT. With the
// default IDLE_BIT of 1, the detector returns to its start state between words.
// Optional GAP_CYCLES of idle fill are forced after every word.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   load_data  in   word to serialize
//   load_valid in   load_data is valid
//   load_ready out  a word can be accepted this cycle
//   abort      in   synchronous cancel of the current word or gap
//   ser_out    out  serial bit to the detector
//   ser_valid  out  ser_out carries a data bit rather than idle fill
//   busy       out  block is not idle
//   done       out  one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_BIT   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] GCNT_INIT =
    (GAP_CYCLES > 0) ? GCNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [WIDTH-1:0]  SHREG_IDLE = {WIDTH{IDLE_BIT}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [GCNT_W-1:0] gcnt_q,  gcnt_d;
  logic              done_q,  done_d;

  logic last_bit;
  logic accept;

  // The last data bit of a word is on the line; with no gap configured a new
  // word may be taken here to produce a seamless stream.
  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == ST_IDLE) ||
                      (last_bit && (GAP_CYCLES == 0) && !abort);
  // Abort wins over a concurrent load, including in IDLE where load_ready
  // is already high.
  assign accept     = load_valid && load_ready && !abort;

  assign ser_out   = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
  assign ser_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  always_comb begin
    // NOTE: every signal assigned here starts from a default, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      shreg_d = SHREG_IDLE;
      cnt_d   = '0;
      gcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_d = load_data;
            cnt_d   = CNT_LAST;
            state_d = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], IDLE_BIT};
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (accept) begin
              shreg_d = load_data;
              cnt_d   = CNT_LAST;
            end else if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gcnt_d  = GCNT_INIT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_GAP: begin
          if (gcnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gcnt_d = gcnt_q - 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= SHREG_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the 001 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on ser_out, which drives the detector's serial input.
- Between words, and during optional gap cycles, it drives IDLE_BIT. The default '1' returns the detector to its start state, so no false 0-runs span word boundaries.

Parameters:
WIDTH, 8, word width in bits (>=2)
GAP_CYCLES, 0, number of IDLE_BIT cycles forced after each word (0 = back-to-back allowed)
IDLE_BIT, 1'b1, level driven on ser_out when no word is being shifted

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
load_data  input  WIDTH  word to serialize
load_valid  input  1  load_data valid
load_ready  output  1  block can accept a word this cycle
abort  input  1  synchronous cancel of current word/gap
ser_out  output  1  serial bit to the detector
ser_valid  output  1  ser_out carries a data bit (not idle fill)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last bit of a word is sent

Behaviour:
- States: IDLE, SHIFT, GAP. Registers: shreg[WIDTH-1:0], bit counter cnt, gap counter gcnt, done flop.
- Reset (reset=0, asynchronous): state=IDLE; shreg all IDLE_BIT; cnt=0; gcnt=0; done=0.
- Output values in reset: ser_out=IDLE_BIT, ser_valid=0, busy=0, load_ready=1.
- ser_out = shreg[WIDTH-1] in SHIFT, IDLE_BIT otherwise.
- ser_valid = (state==SHIFT); busy = (state!=IDLE).
- load_ready = (state==IDLE) OR (state==SHIFT AND cnt==0 AND GAP_CYCLES==0 AND abort=0).
- Accept: load_valid & load_ready at a rising edge. On accept: shreg<=load_data, cnt<=WIDTH-1, state<=SHIFT.
- Latency: accept at edge E. load_data[WIDTH-1] is on ser_out in the cycle after E. Bit WIDTH-1-k appears k cycles later. The last bit (bit 0) is in cycle E+WIDTH.
- SHIFT, cnt!=0: shreg<=(shreg<<1) with IDLE_BIT in the LSB; cnt<=cnt-1.
- SHIFT, cnt==0 (last bit), next edge:
  - done<=1.
  - If accept: reload, stay in SHIFT. This gives a gap-free stream and is possible only with GAP_CYCLES=0.
  - Else if GAP_CYCLES>0: state<=GAP, gcnt<=GAP_CYCLES-1.
  - Else: state<=IDLE.
- done: registered, high for exactly one cycle (cycle E+WIDTH+1); otherwise 0.
- GAP: ser_out=IDLE_BIT, load_ready=0. gcnt decrements each cycle; at gcnt==0 the next state is IDLE. The gap lasts exactly GAP_CYCLES cycles.
- IDLE with load_valid=0: hold; shreg unchanged.
- abort=1 at an edge, in any state: state<=IDLE, shreg<=all IDLE_BIT, cnt<=0, gcnt<=0, done<=0. No done pulse for an aborted word.
- abort has priority over accept in the same cycle; the word is not taken.
- A partially sent word is dropped. ser_out returns to IDLE_BIT in the next cycle.
- reset asserted mid-word: immediate return to reset values, with no clock needed.
- load_data/load_valid are ignored when load_ready=0. The upstream source must hold its word until accepted.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with load_valid=1 -> ser_out=1, ser_valid=0, busy=0, done=0. No word taken after release until the first edge with reset=1.
- Single word: WIDTH=8, load 8'h23 once -> ser_out sequence 0,0,1,0,0,0,1,1 in cycles E+1..E+8, then 1. ser_valid=1 for exactly those 8 cycles. done=1 only in cycle E+9. A downstream seq_001 pulses det twice (at stream bits 3 and 7).
- Back-to-back, GAP_CYCLES=0: load_valid held with 8'hA5 then 8'h3C -> 16 contiguous valid bits 10100101 00111100. load_ready=1 in the last-bit cycle of word 1. done pulses at E+9 and E+17.
- Gap insertion, GAP_CYCLES=2: two words queued -> exactly 2 cycles of ser_out=1, ser_valid=0, load_ready=0 between the words. Word 2 starts at E+11.
- Abort: load 8'h00, assert abort in the 4th bit cycle -> the next cycle has ser_out=1, busy=0, and no done pulse. A load presented in the same cycle as abort is not accepted.
- Async reset mid-word: drop reset between clock edges during bit 5 -> outputs go to reset values immediately. A new word after release serializes correctly from its MSB.
